hazard_stall_controller: RTL and testbench

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

---
 rtl/hazard_stall_controller_pkg.sv | 23 ++
 rtl/load_use_detector.sv | 19 +
 rtl/hazard_stall_controller.sv | 137 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions: controller state encoding and default widths.
package hazard_stall_controller_pkg;

    // Default register-address and stall-counter widths
    localparam int unsigned NbRegDefault = 5;
    localparam int unsigned NbCntDefault = 16;

    // Controller states; the encoding is visible on o_state
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRun      = 3'd1,
        StStepWait = 3'd2,
        StStepExec = 3'd3,
        StDrain    = 3'd4,
        StHalted   = 3'd5
    } state_e;

    // True in the states where the pipeline advances and hazards are acted upon
    function automatic logic is_active(input state_e s);
        return (s == StRun) || (s == StStepExec);
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard compare: a load in EX writes a register read by the instruction in ID.
module load_use_detector
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned NB_REG = NbRegDefault
) (
    input  logic              ex_mem_read,
    input  logic [NB_REG-1:0] ex_rt,
    input  logic [NB_REG-1:0] id_rs,
    input  logic [NB_REG-1:0] id_rt,
    output logic              hazard
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency
    always_comb begin
        hazard = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush/halt controller with single-step debug mode.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned NB_REG       = NbRegDefault,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned NB_CNT       = NbCntDefault
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [NB_REG-1:0] i_ID_rs,
    input  logic [NB_REG-1:0] i_ID_rt,
    input  logic [NB_REG-1:0] i_EX_rt,
    input  logic              i_EX_mem_read,
    input  logic              i_branch_taken,
    input  logic              i_halt_decoded,
    input  logic              i_debug_mode,
    input  logic              i_step,
    output logic              o_pipeline_enable,
    output logic              o_pc_write,
    output logic              o_IF_ID_write,
    output logic              o_ID_EX_bubble,
    output logic              o_IF_ID_flush,
    output logic              o_halted,
    output logic [2:0]        o_state,
    output logic [NB_CNT-1:0] o_stall_count
);

    // Drain counter counts DRAIN_CYCLES-1 down to 0, so DRAIN lasts DRAIN_CYCLES cycles
    localparam int unsigned DrainW    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned DrainInit = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DrainInit);
    localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);
    localparam logic [NB_CNT-1:0] CntOne    = NB_CNT'(1);
    localparam logic [NB_CNT-1:0] CntMax    = '1;

    state_e              state_q, state_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic [NB_CNT-1:0]   stall_q, stall_d;
    logic                hazard;

    load_use_detector #(
        .NB_REG (NB_REG)
    ) u_load_use_detector (
        .ex_mem_read (i_EX_mem_read),
        .ex_rt       (i_EX_rt),
        .id_rs       (i_ID_rs),
        .id_rt       (i_ID_rt),
        .hazard      (hazard)
    );

    // Next-state, counter update and same-cycle output decode
    always_comb begin
        state_d           = state_q;
        drain_d           = drain_q;
        stall_d           = stall_q;
        o_pipeline_enable = 1'b0;
        o_pc_write        = 1'b0;
        o_IF_ID_write     = 1'b0;
        o_ID_EX_bubble    = 1'b0;
        o_IF_ID_flush     = 1'b0;
        o_halted          = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = i_debug_mode ? StStepWait : StRun;
            end

            StRun, StStepExec: begin
                o_pipeline_enable = 1'b1;
                o_pc_write        = 1'b1;
                o_IF_ID_write     = 1'b1;
                // A step executes one cycle whatever happens, then waits again
                state_d = (state_q == StStepExec) ? StStepWait : StRun;
                if (hazard) begin
                    // Hold PC and IF/ID, inject a bubble; branch/HALT seen again next cycle
                    o_pc_write     = 1'b0;
                    o_IF_ID_write  = 1'b0;
                    o_ID_EX_bubble = 1'b1;
                    if (stall_q != CntMax) begin
                        stall_d = stall_q + CntOne;
                    end
                end else if (i_halt_decoded) begin
                    o_pc_write    = 1'b0;
                    o_IF_ID_flush = 1'b1;
                    state_d       = StDrain;
                    drain_d       = DrainLoad;
                end else if (i_branch_taken) begin
                    o_IF_ID_flush = 1'b1;
                end
            end

            StStepWait: begin
                if (i_step) begin
                    state_d = StStepExec;
                end
            end

            StDrain: begin
                // Let older instructions retire while nothing new is fetched
                o_pipeline_enable = 1'b1;
                o_IF_ID_write     = 1'b1;
                o_IF_ID_flush     = 1'b1;
                if (drain_q == '0) begin
                    state_d = StHalted;
                end else begin
                    drain_d = drain_q - DrainOne;
                end
            end

            StHalted: begin
                o_halted = 1'b1;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    assign o_state       = state_q;
    assign o_stall_count = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller against a cycle-level behavioural model.
module tb_hazard_stall_controller;

    localparam int NbCnt  = 16;
    localparam int Drain  = 4;
    localparam int CntMax = (1 << NbCnt) - 1;

    localparam int MIdle     = 0;
    localparam int MRun      = 1;
    localparam int MStepWait = 2;
    localparam int MStepExec = 3;
    localparam int MDrain    = 4;
    localparam int MHalted   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       ex_mr = 1'b0, br = 1'b0, hd = 1'b0, dm = 1'b0, st = 1'b0;

    logic             en, pcw, ifw, bub, fl, hlt;
    logic [2:0]       state;
    logic [NbCnt-1:0] cnt;

    hazard_stall_controller dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_ID_rs           (id_rs),
        .i_ID_rt           (id_rt),
        .i_EX_rt           (ex_rt),
        .i_EX_mem_read     (ex_mr),
        .i_branch_taken    (br),
        .i_halt_decoded    (hd),
        .i_debug_mode      (dm),
        .i_step            (st),
        .o_pipeline_enable (en),
        .o_pc_write        (pcw),
        .o_IF_ID_write     (ifw),
        .o_ID_EX_bubble    (bub),
        .o_IF_ID_flush     (fl),
        .o_halted          (hlt),
        .o_state           (state),
        .o_stall_count     (cnt)
    );

    typedef struct packed {
        logic             en;
        logic             pcw;
        logic             ifw;
        logic             bub;
        logic             fl;
        logic             hlt;
        logic [2:0]       st;
        logic [NbCnt-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Model: mode, remaining drain cycles (including the current one), stall total
    int m_state = MIdle, m_drain = 0, m_stall = 0;
    int n_state = MIdle, n_drain = 0, n_stall = 0;
    int pass_cnt = 0, check_cnt = 0;
    int cyc = 0;

    function automatic exp_t model_eval();
        exp_t e;
        logic hz;
        int   back;
        e       = '0;
        e.st    = 3'(m_state);
        e.cnt   = NbCnt'(m_stall);
        n_state = m_state;
        n_drain = m_drain;
        n_stall = m_stall;
        hz = ex_mr && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
        if (m_state == MIdle) begin
            n_state = dm ? MStepWait : MRun;
        end else if (m_state == MRun || m_state == MStepExec) begin
            e.en = 1'b1;
            back = (m_state == MStepExec) ? MStepWait : MRun;
            if (hz) begin
                e.bub   = 1'b1;
                n_stall = (m_stall < CntMax) ? m_stall + 1 : CntMax;
                n_state = back;
            end else if (hd) begin
                e.ifw   = 1'b1;
                e.fl    = 1'b1;
                n_state = MDrain;
                n_drain = Drain;
            end else begin
                e.pcw   = 1'b1;
                e.ifw   = 1'b1;
                e.fl    = br;
                n_state = back;
            end
        end else if (m_state == MStepWait) begin
            if (st) n_state = MStepExec;
        end else if (m_state == MDrain) begin
            e.en  = 1'b1;
            e.ifw = 1'b1;
            e.fl  = 1'b1;
            if (m_drain <= 1) n_state = MHalted;
            else n_drain = m_drain - 1;
        end else begin
            e.hlt = 1'b1;
        end
        return e;
    endfunction

    // One clock of stimulus: advance the model, apply inputs, queue the expectation
    task automatic drive(input logic rv, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] xrt, input logic mr, input logic b,
                         input logic h, input logic d, input logic s);
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_state = n_state;
            m_drain = n_drain;
            m_stall = n_stall;
        end
        rst_n = rv;
        if (!rv) begin
            m_state = MIdle;
            m_drain = 0;
            m_stall = 0;
        end
        id_rs = rs;
        id_rt = rt;
        ex_rt = xrt;
        ex_mr = mr;
        br    = b;
        hd    = h;
        dm    = d;
        st    = s;
        exp_q.push_back(model_eval());
    endtask

    task automatic quiet(input int n, input logic d);
        for (int i = 0; i < n; i++) drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, d, 1'b0);
    endtask

    task automatic rand_cycle();
        drive(1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom % 2), 1'($urandom % 4 == 0),
              1'($urandom % 48 == 0), 1'($urandom % 2), 1'($urandom % 3 == 0));
    endtask

    task automatic do_reset(input logic d);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, d, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, d, 1'b0);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {en, pcw, ifw, bub, fl, hlt, state, cnt};
            check_cnt++;
            if (a === e) begin
                pass_cnt++;
            end else begin
                $display("FAIL outputs cyc=%0d: actual en=%b pcw=%b ifw=%b bub=%b fl=%b hlt=%b st=%0d cnt=%0d required en=%b pcw=%b ifw=%b bub=%b fl=%b hlt=%b st=%0d cnt=%0d",
                         cyc, a.en, a.pcw, a.ifw, a.bub, a.fl, a.hlt, a.st, a.cnt,
                         e.en, e.pcw, e.ifw, e.bub, e.fl, e.hlt, e.st, e.cnt);
            end
            cyc++;
        end
    end

    initial begin
        // Reset state, then leave IDLE into RUN
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        quiet(2, 1'b0);

        // Load-use on rs, then load to r0 with a taken branch
        drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        quiet(1, 1'b0);
        drive(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        quiet(1, 1'b0);

        // HALT in RUN overriding a branch; stray steps during DRAIN/HALTED are ignored
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Debug mode: three step pulses separated by idle cycles
        do_reset(1'b1);
        quiet(2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            quiet(2, 1'b0);
        end

        // Hazard together with HALT, then DRAIN, reset during DRAIN cycle 2
        do_reset(1'b0);
        quiet(1, 1'b0);
        drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        quiet(1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        quiet(2, 1'b0);

        // Randomized traffic, recovering from HALTED by reset
        for (int i = 0; i < 1500; i++) begin
            if (m_state == MHalted && ($urandom % 4 == 0)) do_reset(1'($urandom % 2));
            else rand_cycle();
        end

        // Saturate the stall counter and keep hitting hazards
        do_reset(1'b0);
        for (int i = 0; i < CntMax + 3; i++)
            drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
